dmem_responder: RTL and testbench
=================================

# dmem_responder

Multi-cycle data-memory responder on the processor's load/store path. Accepts one doubleword read or write request per transaction from the core, inserts a fixed number of wait states, then completes with a one-cycle `ready` strobe carrying read data or an error flag. Storage is an internal array of 64-bit words addressed by the byte address from the ALU. This replaces the zero-latency data memory wherever the core is given stall support.

## Interface
- `DEPTH_WORDS`, default 32: number of 64-bit words; legal byte addresses are 0 to 8*DEPTH_WORDS-8.
- `WAIT_CYCLES`, default 2: wait-state cycles between acceptance and response, legal range 0–15.
- `clk`  in  1  single clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `req`  in  1  request valid; sampled only in IDLE.
- `we`  in  1  1 = store, 0 = load; sampled with `req`.
- `addr`  in  64  byte address, the ALU result.
- `wdata`  in  64  store data, the second register-file read port.
- `rdata`  out  64  load data, registered.
- `ready`  out  1  one-cycle completion strobe.
- `err`  out  1  fault flag, valid only while `ready`=1.
- `busy`  out  1  high in WAIT and RESP; the core stalls its PC on `busy|req`.

## Operation
- FSM states: IDLE, WAIT, RESP.
- **IDLE**
  - If `req`=1 at an edge, latch `addr`, `we` and `wdata` into `a_q`, `we_q` and `wd_q`.
  - Compute `fault` = (addr[2:0]≠0) OR (addr[63:3] ≥ DEPTH_WORDS) and latch it.
  - Load `cnt`=WAIT_CYCLES.
  - Next state: WAIT if WAIT_CYCLES>0, otherwise RESP.
- **WAIT**
  - Decrement `cnt` each cycle.
  - When `cnt`=1 at an edge, go to RESP. WAIT therefore lasts exactly WAIT_CYCLES cycles.
  - `req`, `we`, `addr` and `wdata` are ignored.
- **RESP**
  - Lasts exactly one cycle; `ready`=1 and `err`=`fault`.
  - Load without fault: `rdata` = mem[a_q[63:3]]. The value is registered on the edge entering RESP.
  - Load with fault: `rdata`=0.
  - Store without fault: mem[a_q[63:3]] ← `wd_q` on the edge leaving RESP. `rdata` is unchanged.
  - Store with fault: memory is unchanged.
  - Next state is always IDLE. A `req` high during RESP is not accepted.
- `rdata` holds its value after RESP until the next load response or reset.
- Addressing:
  - Word index is addr[63:3].
  - No byte or halfword lanes; every access is a full doubleword.
  - No wrap-around: any out-of-range address faults.
- Memory contents are not cleared by reset. Initial contents are undefined, and benches initialise by stores.

## Timing
- Reset values, applied asynchronously:
  - state=IDLE, `cnt`=0.
  - `ready`=0, `err`=0, `busy`=0, `rdata`=0.
  - `a_q`, `we_q`, `wd_q` and `fault` are all 0.
- Latency: with acceptance edge at end of cycle 0, `ready` is high in cycle WAIT_CYCLES+1.
  - WAIT_CYCLES=2 gives `ready` in cycle 3.
  - WAIT_CYCLES=0 gives `ready` in cycle 1.
- `busy` rises in cycle 1, stays high through the RESP cycle, and falls in the cycle after RESP.
- Throughput: the earliest next acceptance is the first IDLE cycle after RESP. Back-to-back transactions take WAIT_CYCLES+2 cycles each.
- Store data is visible to a load accepted in the cycle after that store's RESP.
- Reset asserted in WAIT or RESP:
  - The transaction is abandoned, with no memory write and no `ready` pulse.
  - All outputs go to their reset values immediately.
- Reset deasserted with `req`=1: the request is accepted at the first edge after deassertion.
- `err` is never high while `ready`=0.

## Test plan
- Store 64'hDEAD_BEEF_0123_4567 to addr 0x10, then load 0x10 (WAIT_CYCLES=2):
  - Each `ready` pulses one cycle, 3 cycles after acceptance.
  - The load returns DEAD_BEEF_0123_4567 with `err`=0.
- Misaligned load at addr 0x0C, and load at 0x100 (word 32 ≥ DEPTH_WORDS):
  - Each gives `ready`=1, `err`=1, `rdata`=0.
- Faulting store:
  - Prior contents of 0x08 = 64'h1111. Store 64'h2222 to misaligned addr 0x0B.
  - Response is `err`=1; a subsequent load of 0x08 returns 64'h1111.
- `req` held high continuously with varying addresses:
  - Acceptances occur every 4 cycles.
  - `req` changes during WAIT and RESP are ignored; `busy` stays high exactly WAIT, WAIT and RESP.
- Store 64'hAAAA to 0x18, asserting `reset` one cycle after acceptance:
  - `busy` and `ready` go to 0 immediately and no `ready` pulse occurs.
  - A later load of 0x18 returns the previous value, 64'h5555 written before the test.
- WAIT_CYCLES=0 build, store then load at 0x0:
  - `ready` appears in the cycle after acceptance.
  - Back-to-back period is 2 cycles; data round-trips correctly.

Source files
------------

// File: rtl/dmem_responder.sv
// Multi-cycle doubleword data memory for the core's load/store path: accepts one
// request in IDLE, waits WAIT_CYCLES, then completes with a one-cycle ready strobe.
module dmem_responder #(
  parameter int DEPTH_WORDS = 32,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic [63:0] addr,
  input  logic [63:0] wdata,
  output logic [63:0] rdata,
  output logic        ready,
  output logic        err,
  output logic        busy,
  output logic [1:0]  dbg_state
);

  localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  // Handshake: req/we/addr/wdata are sampled only at an edge in IDLE; the core holds
  // its PC while busy|req, and the transaction completes on the single cycle ready=1.

  state_t          r_state;
  state_t          w_next;
  logic [3:0]      r_cnt;
  logic [AW-1:0]   r_idx_q;
  logic [63:0]     r_wd_q;
  logic            r_we_q;
  logic            r_fault;
  logic [63:0]     r_rdata;
  logic [63:0]     r_mem [DEPTH_WORDS];

  logic            w_accept;
  logic            w_fault_in;
  logic            w_enter_resp;
  logic            w_rd_we;
  logic            w_rd_fault;
  logic [AW-1:0]   w_rd_idx;

  assign w_accept   = (r_state == S_IDLE) && req;
  assign w_fault_in = (addr[2:0] != 3'd0) || (addr[63:3] >= 61'(DEPTH_WORDS));

  // With zero wait states RESP is entered straight from IDLE, so the read must use the live request.
  assign w_enter_resp = (w_next == S_RESP) && (r_state != S_RESP);
  assign w_rd_we      = (r_state == S_IDLE) ? we : r_we_q;
  assign w_rd_fault   = (r_state == S_IDLE) ? w_fault_in : r_fault;
  assign w_rd_idx     = (r_state == S_IDLE) ? addr[AW+2:3] : r_idx_q;

  always_comb begin
    w_next = r_state;
    ready  = 1'b0;
    busy   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (req) w_next = (WAIT_CYCLES > 0) ? S_WAIT : S_RESP;
      end
      S_WAIT: begin
        busy = 1'b1;
        if (r_cnt == 4'd1) w_next = S_RESP;
      end
      S_RESP: begin
        busy   = 1'b1;
        ready  = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  assign err       = ready & r_fault;
  assign rdata     = r_rdata;
  assign dbg_state = r_state;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
      r_idx_q <= '0;
      r_wd_q  <= 64'd0;
      r_we_q  <= 1'b0;
      r_fault <= 1'b0;
      r_rdata <= 64'd0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_idx_q <= addr[AW+2:3];
        r_wd_q  <= wdata;
        r_we_q  <= we;
        r_fault <= w_fault_in;
        r_cnt   <= 4'(WAIT_CYCLES);
      end else if (r_state == S_WAIT) begin
        r_cnt <= r_cnt - 4'd1;
      end
      if (w_enter_resp && !w_rd_we) begin
        r_rdata <= w_rd_fault ? 64'd0 : r_mem[w_rd_idx];
      end
    end
  end

  // Storage is deliberately not reset; an abandoned store never reaches RESP, so it never writes.
  always_ff @(posedge clk) begin
    if ((r_state == S_RESP) && r_we_q && !r_fault) begin
      r_mem[r_idx_q] <= r_wd_q;
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: a WAIT_CYCLES=2 instance and a WAIT_CYCLES=0 instance,
// selected by sel, checked against a reference memory model through an expected queue.
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic        req, we, sel;
  logic [63:0] addr, wdata;

  logic        a_req, b_req;
  logic [63:0] a_rdata, b_rdata, m_rdata;
  logic        a_ready, b_ready, m_ready;
  logic        a_err, b_err, m_err;
  logic        a_busy, b_busy, m_busy;
  logic [1:0]  a_dbg, b_dbg;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [64:0] exp_q[$];
  logic [63:0] mm[int];
  logic [63:0] last_rd[2];

  // clock / reset
  always #5 clk = ~clk;

  assign a_req   = req & ~sel;
  assign b_req   = req & sel;
  assign m_ready = sel ? b_ready : a_ready;
  assign m_err   = sel ? b_err   : a_err;
  assign m_busy  = sel ? b_busy  : a_busy;
  assign m_rdata = sel ? b_rdata : a_rdata;

  dmem_responder #(.DEPTH_WORDS(32), .WAIT_CYCLES(2)) u_dut (
    .clk(clk), .reset(reset), .req(a_req), .we(we), .addr(addr), .wdata(wdata),
    .rdata(a_rdata), .ready(a_ready), .err(a_err), .busy(a_busy), .dbg_state(a_dbg)
  );

  dmem_responder #(.DEPTH_WORDS(32), .WAIT_CYCLES(0)) u_dut0 (
    .clk(clk), .reset(reset), .req(b_req), .we(we), .addr(addr), .wdata(wdata),
    .rdata(b_rdata), .ready(b_ready), .err(b_err), .busy(b_busy), .dbg_state(b_dbg)
  );

  // reference model: returns {err, rdata} expected at the response
  function automatic logic [64:0] model(input logic s, input logic w,
                                        input logic [63:0] a, input logic [63:0] d);
    logic        f;
    int          key;
    logic [63:0] rd;
    f   = (a[2:0] != 3'd0) || (a[63:3] >= 61'd32);
    key = {26'd0, s, a[7:3]};
    if (w) begin
      if (!f) mm[key] = d;
      rd = last_rd[s];
    end else begin
      rd = f ? 64'd0 : mm[key];
      last_rd[s] = rd;
    end
    return {f, rd};
  endfunction

  always @(negedge clk) begin
    if (!reset) begin
      n_checks++;
      if ((a_err && !a_ready) || (b_err && !b_ready)) begin
        n_errors++;
        $display("FAIL err_without_ready: a_err=%b a_ready=%b b_err=%b b_ready=%b required err low",
                 a_err, a_ready, b_err, b_ready);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // driver: wait for the response of the transaction accepted at the last edge
  task automatic wait_resp(input logic s, input string nm);
    int          lat;
    int          exp_lat;
    logic [64:0] e, got;
    exp_lat = s ? 1 : 3;
    lat = 0;
    while (lat < 20) begin
      @(negedge clk);
      lat++;
      if (m_ready === 1'b1) break;
      n_checks++;
      if (m_busy !== 1'b1) begin
        n_errors++;
        $display("FAIL %s_busy: cycle %0d busy=%b required 1", nm, lat, m_busy);
      end
      req   = 1'($urandom_range(0, 1));
      we    = 1'($urandom_range(0, 1));
      addr  = {$urandom, $urandom};
      wdata = {$urandom, $urandom};
    end
    req = 1'b0;
    n_checks++;
    if (lat != exp_lat) begin
      n_errors++;
      $display("FAIL %s_latency: ready in cycle %0d required cycle %0d", nm, lat, exp_lat);
    end
    got = {m_err, m_rdata};
    e   = (exp_q.size() > 0) ? exp_q.pop_front() : 65'hx;
    n_checks++;
    if (got !== e) begin
      n_errors++;
      $display("FAIL %s_resp: got err/rdata %h required %h", nm, got, e);
    end
    @(negedge clk);
    n_checks++;
    if (m_ready !== 1'b0 || m_busy !== 1'b0) begin
      n_errors++;
      $display("FAIL %s_after: ready=%b busy=%b required 0 0", nm, m_ready, m_busy);
    end
  endtask

  task automatic txn(input logic s, input logic w, input logic [63:0] a,
                     input logic [63:0] d, input string nm);
    sel = s;
    exp_q.push_back(model(s, w, a, d));
    @(negedge clk);
    req = 1'b1; we = w; addr = a; wdata = d;
    wait_resp(s, nm);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({a_ready, a_err, a_busy} !== 3'b000) begin
      n_errors++;
      $display("FAIL reset_flags: ready/err/busy=%b required 000", {a_ready, a_err, a_busy});
    end
    n_checks++;
    if (a_rdata !== 64'd0) begin
      n_errors++;
      $display("FAIL reset_rdata: got %h required 0", a_rdata);
    end
    n_checks++;
    if (a_dbg !== 2'd0) begin
      n_errors++;
      $display("FAIL reset_state: got %0d required 0 (IDLE)", a_dbg);
    end
    sel = 1'b0;
    exp_q.push_back(model(1'b0, 1'b0, 64'h0C, 64'd0));
    req = 1'b1; we = 1'b0; addr = 64'h0C; wdata = 64'd0;
    reset = 1'b0;
    wait_resp(1'b0, "reset_release");
  endtask

  task automatic test_store_load();
    txn(1'b0, 1'b1, 64'h10, 64'hDEAD_BEEF_0123_4567, "store_10");
    txn(1'b0, 1'b0, 64'h10, 64'd0, "load_10");
    n_checks++;
    if (a_rdata !== 64'hDEAD_BEEF_0123_4567) begin
      n_errors++;
      $display("FAIL load_10_value: got %h required DEADBEEF01234567", a_rdata);
    end
  endtask

  task automatic test_fault_load();
    txn(1'b0, 1'b0, 64'h0C, 64'd0, "load_misaligned");
    txn(1'b0, 1'b0, 64'h100, 64'd0, "load_out_of_range");
  endtask

  task automatic test_fault_store();
    txn(1'b0, 1'b1, 64'h08, 64'h1111, "store_08");
    txn(1'b0, 1'b1, 64'h0B, 64'h2222, "store_misaligned");
    txn(1'b0, 1'b0, 64'h08, 64'd0, "load_08");
    n_checks++;
    if (a_rdata !== 64'h1111) begin
      n_errors++;
      $display("FAIL fault_store_kept: got %h required 1111", a_rdata);
    end
  endtask

  task automatic test_reset_mid();
    txn(1'b0, 1'b1, 64'h18, 64'h5555, "store_18");
    sel = 1'b0;
    @(negedge clk);
    req = 1'b1; we = 1'b1; addr = 64'h18; wdata = 64'hAAAA;
    @(negedge clk);
    req = 1'b0;
    n_checks++;
    if (a_busy !== 1'b1) begin
      n_errors++;
      $display("FAIL midreset_busy_before: got %b required 1", a_busy);
    end
    #1 reset = 1'b1;
    #1;
    n_checks++;
    if ({a_busy, a_ready, a_err} !== 3'b000 || a_rdata !== 64'd0) begin
      n_errors++;
      $display("FAIL midreset_outputs: busy/ready/err=%b rdata=%h required 000 and 0",
               {a_busy, a_ready, a_err}, a_rdata);
    end
    last_rd[0] = 64'd0;
    last_rd[1] = 64'd0;
    repeat (3) begin
      @(negedge clk);
      n_checks++;
      if (a_ready !== 1'b0) begin
        n_errors++;
        $display("FAIL midreset_no_ready: got %b required 0", a_ready);
      end
    end
    reset = 1'b0;
    txn(1'b0, 1'b0, 64'h18, 64'd0, "load_18");
    n_checks++;
    if (a_rdata !== 64'h5555) begin
      n_errors++;
      $display("FAIL midreset_mem: got %h required 5555", a_rdata);
    end
  endtask

  task automatic test_wait0();
    txn(1'b1, 1'b1, 64'h0, 64'hCAFE_F00D_1234_5678, "w0_store");
    txn(1'b1, 1'b0, 64'h0, 64'd0, "w0_load");
    n_checks++;
    if (b_rdata !== 64'hCAFE_F00D_1234_5678) begin
      n_errors++;
      $display("FAIL w0_value: got %h required CAFEF00D12345678", b_rdata);
    end
  endtask

  // req held high; only the acceptance-edge inputs may matter
  task automatic test_back_to_back(input logic s, input int n);
    int          p;
    int          pick;
    logic [63:0] alist[5];
    logic [63:0] a, d;
    logic        w;
    logic [64:0] e, got;
    p = s ? 2 : 4;
    if (s) begin
      alist[0] = 64'h0;  alist[1] = 64'h03; alist[2] = 64'h400;
      alist[3] = 64'h0;  alist[4] = 64'h0;
    end else begin
      alist[0] = 64'h08; alist[1] = 64'h10; alist[2] = 64'h18;
      alist[3] = 64'h0C; alist[4] = 64'h100;
    end
    sel = s;
    for (int k = 0; k < n * p; k++) begin
      @(negedge clk);
      if (k > 0) begin
        n_checks++;
        if (m_ready !== ((k % p) == p - 1)) begin
          n_errors++;
          $display("FAIL b2b_ready: cycle %0d got %b required %b", k, m_ready, ((k % p) == p - 1));
        end
        n_checks++;
        if (m_busy !== ((k % p) != 0)) begin
          n_errors++;
          $display("FAIL b2b_busy: cycle %0d got %b required %b", k, m_busy, ((k % p) != 0));
        end
      end
      if (m_ready === 1'b1) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_errors++;
          $display("FAIL b2b_extra: unexpected ready in cycle %0d", k);
        end else begin
          e   = exp_q.pop_front();
          got = {m_err, m_rdata};
          if (got !== e) begin
            n_errors++;
            $display("FAIL b2b_resp: cycle %0d got %h required %h", k, got, e);
          end
        end
      end
      if ((k % p) == 0) begin
        pick = $urandom_range(0, 4);
        a = alist[pick];
        w = 1'($urandom_range(0, 1));
        d = {$urandom, $urandom};
        exp_q.push_back(model(s, w, a, d));
        req = 1'b1; we = w; addr = a; wdata = d;
      end else begin
        req   = (k != n * p - 1);
        we    = 1'($urandom_range(0, 1));
        addr  = {$urandom, $urandom};
        wdata = {$urandom, $urandom};
      end
    end
    @(negedge clk);
    n_checks++;
    if (m_ready !== 1'b0 || m_busy !== 1'b0 || exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL b2b_end: ready=%b busy=%b pending=%0d required 0 0 0",
               m_ready, m_busy, exp_q.size());
    end
  endtask

  initial begin
    reset = 1'b1; req = 1'b0; we = 1'b0; addr = 64'd0; wdata = 64'd0; sel = 1'b0;
    last_rd[0] = 64'd0;
    last_rd[1] = 64'd0;
    test_reset();
    test_store_load();
    test_fault_load();
    test_fault_store();
    test_reset_mid();
    test_back_to_back(1'b0, 6);
    test_wait0();
    test_back_to_back(1'b1, 8);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
